decode_wide: RTL and testbench

Parametrised superscalar front-end decoder. It decodes up to NWIDTH fetched instructions per cycle into `t_uinstr` micro-ops and buffers them in an internal micro-op queue. It sits between fetch (FE1) and rename (RN0), replacing the single-wide decoder. It adds full S/U/J format decode, width-dependent load/store sizes, multi-slot push and pop, and a queue flush on nuke.

---
 rtl/decode_wide_pkg.sv | 159 +++++++++++++++
 rtl/decode_wide_slot.sv | 77 +++++++
 rtl/decode_wide.sv | 103 ++++++++++
 tb/tb_decode_wide.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_wide_pkg.sv
// Shared types and instruction-field helpers for the wide decoder and its per-slot decode.
package decode_wide_pkg;

  typedef enum logic [1:0] {SZ_1B = 2'd0, SZ_2B, SZ_4B, SZ_8B} t_opsize;
  typedef enum logic [1:0] {OP_INVD = 2'd0, OP_REG, OP_IMM, OP_ZERO} t_optype;
  typedef enum logic [2:0] {IF_UNKN = 3'd0, IF_R, IF_I, IF_S, IF_B, IF_U, IF_J} t_ifmt;
  typedef enum logic [4:0] {
    U_INVALID = 5'd0, U_ADD, U_SUB, U_SLL, U_SLT, U_SLTU, U_XOR, U_SRL, U_SRA, U_OR, U_AND,
    U_LD, U_ST, U_BR, U_JAL, U_JALR, U_LUI, U_AUIPC, U_FENCE, U_ECALL, U_EBREAK
  } t_uop;

  localparam logic [6:0] RV_LOAD     = 7'b0000011;
  localparam logic [6:0] RV_MISC_MEM = 7'b0001111;
  localparam logic [6:0] RV_OP_IMM   = 7'b0010011;
  localparam logic [6:0] RV_AUIPC    = 7'b0010111;
  localparam logic [6:0] RV_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] RV_STORE    = 7'b0100011;
  localparam logic [6:0] RV_OP       = 7'b0110011;
  localparam logic [6:0] RV_LUI      = 7'b0110111;
  localparam logic [6:0] RV_OP32     = 7'b0111011;
  localparam logic [6:0] RV_BRANCH   = 7'b1100011;
  localparam logic [6:0] RV_JALR     = 7'b1100111;
  localparam logic [6:0] RV_JAL      = 7'b1101111;
  localparam logic [6:0] RV_SYSTEM   = 7'b1110011;

  typedef struct packed {
    t_optype    optype;
    t_opsize    opsize;
    logic [4:0] rnum;
  } t_rv_reg_op;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
`ifdef SIMULATION
    logic [31:0] simid;
`endif
  } t_instr_pkt;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    logic        valid;
    t_uop        uop;
    logic [6:0]  opcode;
    logic [63:0] pc;
    t_rv_reg_op  dst;
    t_rv_reg_op  src1;
    t_rv_reg_op  src2;
    logic [63:0] imm64;
`ifdef SIMULATION
    logic [31:0] simid;
`endif
  } t_uinstr;

  typedef struct packed {
    t_ifmt       ifmt;
    logic [6:0]  opcode;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
  } t_instr_fmt;

  function automatic t_rv_reg_op mk_op(input t_optype t, input t_opsize s, input logic [4:0] r);
    t_rv_reg_op o;
    o.optype = t;
    o.opsize = s;
    o.rnum   = r;
    return o;
  endfunction

  function automatic t_opsize ld_st_opsize(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return SZ_1B;
      2'd1:    return SZ_2B;
      2'd2:    return SZ_4B;
      default: return SZ_8B;
    endcase
  endfunction

  function automatic logic [63:0] imm_i(input logic [31:0] i);
    return {{52{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [63:0] imm_s(input logic [31:0] i);
    return {{52{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [63:0] imm_b(input logic [31:0] i);
    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] imm_u(input logic [31:0] i);
    return {{32{i[31]}}, i[31:12], 12'b0};
  endfunction

  function automatic logic [63:0] imm_j(input logic [31:0] i);
    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic t_instr_fmt get_instr_format(input t_instr_pkt p);
    t_instr_fmt f;
    f.opcode = p.instr[6:0];
    f.pc     = p.pc;
    f.rd     = p.instr[11:7];
    f.rs1    = p.instr[19:15];
    f.rs2    = p.instr[24:20];
    f.funct3 = p.instr[14:12];
    case (p.instr[6:0])
      RV_OP, RV_OP32:                          f.ifmt = IF_R;
      RV_LOAD, RV_OP_IMM, RV_OP_IMM32,
      RV_JALR, RV_SYSTEM, RV_MISC_MEM:         f.ifmt = IF_I;
      RV_STORE:                                f.ifmt = IF_S;
      RV_BRANCH:                               f.ifmt = IF_B;
      RV_LUI, RV_AUIPC:                        f.ifmt = IF_U;
      RV_JAL:                                  f.ifmt = IF_J;
      default:                                 f.ifmt = IF_UNKN;
    endcase
    return f;
  endfunction

  function automatic t_uop alu_uop(input logic [2:0] funct3, input logic alt, input logic is_reg);
    case (funct3)
      3'd0:    return (is_reg && alt) ? U_SUB : U_ADD;
      3'd1:    return U_SLL;
      3'd2:    return U_SLT;
      3'd3:    return U_SLTU;
      3'd4:    return U_XOR;
      3'd5:    return alt ? U_SRA : U_SRL;
      3'd6:    return U_OR;
      default: return U_AND;
    endcase
  endfunction

  function automatic t_uop rv_instr_to_uop(input logic [31:0] i);
    case (i[6:0])
      RV_LUI:                  return U_LUI;
      RV_AUIPC:                return U_AUIPC;
      RV_JAL:                  return U_JAL;
      RV_JALR:                 return U_JALR;
      RV_BRANCH:               return U_BR;
      RV_LOAD:                 return U_LD;
      RV_STORE:                return U_ST;
      RV_MISC_MEM:             return U_FENCE;
      RV_OP, RV_OP32:          return alu_uop(i[14:12], i[30], 1'b1);
      RV_OP_IMM, RV_OP_IMM32:  return alu_uop(i[14:12], i[30], 1'b0);
      RV_SYSTEM: begin
        if (i[14:12] == 3'd0 && i[31:21] == 11'd0) return i[20] ? U_EBREAK : U_ECALL;
        return U_INVALID;
      end
      default:                 return U_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/decode_wide_slot.sv
// Single-instruction combinational decode of a fetched instruction into a micro-op.
module decode_slot
  import decode_wide_pkg::*;
(
  input  logic       valid,
  input  t_instr_pkt instr,
  output t_uinstr    uinstr
);

  t_instr_fmt fmt;
  t_opsize    sz_alu;
  t_uinstr    u;

  always_comb begin
    fmt    = get_instr_format(instr);
    sz_alu = fmt.opcode[3] ? SZ_4B : SZ_8B;
    u        = '0;
    u.valid  = valid;
    u.opcode = fmt.opcode;
    u.pc     = fmt.pc;
`ifdef SIMULATION
    u.simid  = instr.simid;
`endif
    if (fmt.ifmt != IF_UNKN) u.uop = rv_instr_to_uop(instr.instr);

    case (fmt.ifmt)
      IF_R: begin
        u.dst  = mk_op(OP_REG, sz_alu, fmt.rd);
        u.src1 = mk_op(OP_REG, sz_alu, fmt.rs1);
        u.src2 = mk_op(OP_REG, sz_alu, fmt.rs2);
      end
      IF_I: begin
        u.imm64 = imm_i(instr.instr);
        if (fmt.opcode == RV_LOAD) begin
          u.dst  = mk_op(OP_REG, ld_st_opsize(fmt.funct3), fmt.rd);
          u.src1 = mk_op(OP_REG, SZ_8B, fmt.rs1);
          u.src2 = mk_op(OP_IMM, SZ_8B, 5'd0);
        end else if (fmt.opcode == RV_JALR) begin
          u.dst  = mk_op(OP_REG, SZ_8B, fmt.rd);
          u.src1 = mk_op(OP_REG, SZ_8B, fmt.rs1);
          u.src2 = mk_op(OP_IMM, SZ_8B, 5'd0);
        end else begin
          u.dst  = mk_op(OP_REG, sz_alu, fmt.rd);
          u.src1 = mk_op(OP_REG, sz_alu, fmt.rs1);
          u.src2 = mk_op(OP_IMM, sz_alu, 5'd0);
        end
      end
      IF_S: begin
        u.src1  = mk_op(OP_REG, SZ_8B, fmt.rs1);
        u.src2  = mk_op(OP_REG, ld_st_opsize(fmt.funct3), fmt.rs2);
        u.imm64 = imm_s(instr.instr);
      end
      IF_B: begin
        u.src1  = mk_op(OP_REG, SZ_8B, fmt.rs1);
        u.src2  = mk_op(OP_REG, SZ_8B, fmt.rs2);
        u.imm64 = imm_b(instr.instr);
      end
      IF_U: begin
        u.dst   = mk_op(OP_REG, SZ_8B, fmt.rd);
        u.imm64 = imm_u(instr.instr);
      end
      IF_J: begin
        u.dst   = mk_op(OP_REG, SZ_8B, fmt.rd);
        u.imm64 = imm_j(instr.instr);
      end
      default: ;
    endcase

    // x0 handling runs after format decode so every format gets it uniformly
    if (u.src1.optype == OP_REG && u.src1.rnum == 5'd0) u.src1.optype = OP_ZERO;
    if (u.src2.optype == OP_REG && u.src2.rnum == 5'd0) u.src2.optype = OP_ZERO;
    if (u.dst.optype  == OP_REG && u.dst.rnum  == 5'd0) u.dst.optype  = OP_INVD;

    uinstr = u;
  end

endmodule

// File: rtl/decode_wide.sv
// NWIDTH-wide front-end decoder: per-slot decode feeding a multi-push/multi-pop micro-op ring buffer.
module decode_wide
  import decode_wide_pkg::*;
#(
  parameter int unsigned NWIDTH     = 2,
  parameter int unsigned UOPQ_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  t_nuke_pkt                           nuke_rb1,
  input  logic [NWIDTH-1:0]                   valid_fe1,
  input  t_instr_pkt [NWIDTH-1:0]             instr_fe1,
  output logic                                decode_ready_de0,
  input  logic                                rename_ready_rn0,
  output t_uinstr [NWIDTH-1:0]                uinstr_de0,
  output logic [NWIDTH-1:0]                   valid_de1,
  output t_uinstr [NWIDTH-1:0]                uinstr_de1,
  output logic [$clog2(UOPQ_DEPTH+1)-1:0]     uopq_cnt_de1
);

  localparam int unsigned PW = $clog2(UOPQ_DEPTH);
  localparam int unsigned CW = $clog2(UOPQ_DEPTH+1);

  t_uinstr          dec  [NWIDTH];
  t_uinstr          uopq [UOPQ_DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW-1:0]    wr_ptr [NWIDTH];
  logic [CW-1:0]    count, count_next, npush, npop, avail;
  logic [NWIDTH-1:0] push;
  logic             ebreak_seen, eb_push, ready, blocked;

  for (genvar g = 0; g < NWIDTH; g++) begin : g_slot
    decode_slot u_slot (
      .valid  (valid_fe1[g]),
      .instr  (instr_fe1[g]),
      .uinstr (dec[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < NWIDTH; i++) uinstr_de0[i] = reset_n ? dec[i] : '0;
  end

  assign ready            = reset_n && (count <= CW'(UOPQ_DEPTH - NWIDTH));
  assign decode_ready_de0 = ready;
  assign uopq_cnt_de1     = count;

  // An EBREAK blocks every younger slot; push slots stay contiguous from slot 0.
  always_comb begin
    push    = '0;
    npush   = '0;
    eb_push = 1'b0;
    blocked = ebreak_seen | nuke_rb1.valid | ~ready;
    for (int unsigned i = 0; i < NWIDTH; i++) begin
      wr_ptr[i] = tail + PW'(npush);
      if (valid_fe1[i] && !blocked) begin
        push[i] = 1'b1;
        npush   = npush + CW'(1);
        if (dec[i].uop == U_EBREAK) begin
          eb_push = 1'b1;
          blocked = 1'b1;
        end
      end
    end
  end

  always_comb begin
    avail      = (count < CW'(NWIDTH)) ? count : CW'(NWIDTH);
    npop       = (rename_ready_rn0 && !nuke_rb1.valid) ? avail : '0;
    count_next = count + npush - npop;
    for (int unsigned i = 0; i < NWIDTH; i++) begin
      valid_de1[i]        = CW'(i) < npop;
      uinstr_de1[i]       = uopq[head + PW'(i)];
      uinstr_de1[i].valid = valid_de1[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ebreak_seen <= 1'b0;
    end else if (nuke_rb1.valid) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ebreak_seen <= 1'b0;
    end else begin
      head  <= head + PW'(npop);
      tail  <= tail + PW'(npush);
      count <= count_next;
      if (eb_push) ebreak_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NWIDTH; i++) begin
      if (push[i]) uopq[wr_ptr[i]] <= dec[i];
    end
  end

endmodule

// File: tb/tb_decode_wide.sv
// Self-checking bench for decode_wide: decode vector table plus queue/ebreak/nuke/reset sequences.
module tb_decode_wide;
  import decode_wide_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  t_nuke_pkt            nuke;
  logic [1:0]           valid_fe1;
  t_instr_pkt [1:0]     instr_fe1;
  logic                 ready;
  logic                 rename_ready;
  t_uinstr [1:0]        uinstr_de0;
  t_uinstr [1:0]        uinstr_de1;
  logic [1:0]           valid_de1;
  logic [3:0]           cnt;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  localparam logic [31:0] I_ADDI   = 32'h00108093;
  localparam logic [31:0] I_ADD    = 32'h003100B3;
  localparam logic [31:0] I_EBREAK = 32'h00100073;

  decode_wide #(.NWIDTH(2), .UOPQ_DEPTH(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .nuke_rb1         (nuke),
    .valid_fe1        (valid_fe1),
    .instr_fe1        (instr_fe1),
    .decode_ready_de0 (ready),
    .rename_ready_rn0 (rename_ready),
    .uinstr_de0       (uinstr_de0),
    .valid_de1        (valid_de1),
    .uinstr_de1       (uinstr_de1),
    .uopq_cnt_de1     (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    t_optype     dt;  t_opsize ds;  logic [4:0] dr;
    t_optype     s1t; logic [4:0] s1r;
    t_optype     s2t; t_opsize s2s; logic [4:0] s2r;
    logic [63:0] imm;
  } t_vec;

  t_vec vecs[12];

  function automatic t_vec mk(input string n, input logic [31:0] ins,
                              input t_optype dt, input t_opsize ds, input logic [4:0] dr,
                              input t_optype s1t, input logic [4:0] s1r,
                              input t_optype s2t, input t_opsize s2s, input logic [4:0] s2r,
                              input logic [63:0] imm);
    t_vec v;
    v.name = n; v.instr = ins;
    v.dt = dt; v.ds = ds; v.dr = dr;
    v.s1t = s1t; v.s1r = s1r;
    v.s2t = s2t; v.s2s = s2s; v.s2r = s2r;
    v.imm = imm;
    return v;
  endfunction

  function automatic bit op_ok(input t_rv_reg_op g, input t_optype t, input t_opsize s,
                               input logic [4:0] r, input bit chk_sz);
    if (g.optype != t) return 1'b0;
    if (t == OP_REG) begin
      if (g.rnum != r) return 1'b0;
      if (chk_sz && g.opsize != s) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic mon();
    logic [63:0] e;
    if (!reset_n) return;
    check("pop_contig", 64'(valid_de1[1] & ~valid_de1[0]), 64'd0);
    for (int i = 0; i < 2; i++) begin
      if (valid_de1[i]) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_underflow got pc=%0h exp=<none>", uinstr_de1[i].pc);
        end else begin
          e = sb.pop_front();
          check("pop_pc", uinstr_de1[i].pc, e);
          check("pop_valid", 64'(uinstr_de1[i].valid), 64'd1);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_group(input logic [63:0] pc0, input logic [1:0] v,
                             input logic [31:0] i0, input logic [31:0] i1, input int npush);
    instr_fe1          = '0;
    instr_fe1[0].instr = i0;
    instr_fe1[0].pc    = pc0;
    instr_fe1[1].instr = i1;
    instr_fe1[1].pc    = pc0 + 64'd4;
    valid_fe1          = v;
    for (int k = 0; k < npush; k++) sb.push_back(pc0 + 64'(4 * k));
  endtask

  initial begin
    vecs[0]  = mk("addi_m1",  32'hFFF00293, OP_REG,  SZ_8B, 5'd5, OP_ZERO, 5'd0, OP_IMM,  SZ_8B, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[1]  = mk("lui",      32'h800000B7, OP_REG,  SZ_8B, 5'd1, OP_INVD, 5'd0, OP_INVD, SZ_8B, 5'd0, 64'hFFFF_FFFF_8000_0000);
    vecs[2]  = mk("sw",       32'hFE712E23, OP_INVD, SZ_8B, 5'd0, OP_REG,  5'd2, OP_REG,  SZ_4B, 5'd7, 64'hFFFF_FFFF_FFFF_FFFC);
    vecs[3]  = mk("lb",       32'h00020183, OP_REG,  SZ_1B, 5'd3, OP_REG,  5'd4, OP_IMM,  SZ_8B, 5'd0, 64'd0);
    vecs[4]  = mk("ld",       32'h00823183, OP_REG,  SZ_8B, 5'd3, OP_REG,  5'd4, OP_IMM,  SZ_8B, 5'd0, 64'd8);
    vecs[5]  = mk("addw",     32'h0000833B, OP_REG,  SZ_4B, 5'd6, OP_REG,  5'd1, OP_ZERO, SZ_4B, 5'd0, 64'd0);
    vecs[6]  = mk("beq",      32'hFE208CE3, OP_INVD, SZ_8B, 5'd0, OP_REG,  5'd1, OP_REG,  SZ_8B, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8);
    vecs[7]  = mk("jal",      32'h001000EF, OP_REG,  SZ_8B, 5'd1, OP_INVD, 5'd0, OP_INVD, SZ_8B, 5'd0, 64'h800);
    vecs[8]  = mk("jalr_x0",  32'h00008067, OP_INVD, SZ_8B, 5'd0, OP_REG,  5'd1, OP_IMM,  SZ_8B, 5'd0, 64'd0);
    vecs[9]  = mk("unknown",  32'hFFFFFFFF, OP_INVD, SZ_8B, 5'd0, OP_INVD, 5'd0, OP_INVD, SZ_8B, 5'd0, 64'd0);
    vecs[10] = mk("sh",       32'h00509323, OP_INVD, SZ_8B, 5'd0, OP_REG,  5'd1, OP_REG,  SZ_2B, 5'd5, 64'd6);
    vecs[11] = mk("lw_min",   32'h8004A403, OP_REG,  SZ_4B, 5'd8, OP_REG,  5'd9, OP_IMM,  SZ_8B, 5'd0, 64'hFFFF_FFFF_FFFF_F800);

    reset_n      = 1'b0;
    nuke         = '0;
    valid_fe1    = '0;
    instr_fe1    = '0;
    rename_ready = 1'b0;
    #1;
    check("rst_cnt",   64'(cnt), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_valid", 64'(valid_de1), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(ready), 64'd1);

    for (int k = 0; k < 12; k++) begin
      bit ok;
      instr_fe1[0].instr = vecs[k].instr;
      #1;
      ok = op_ok(uinstr_de0[0].dst,  vecs[k].dt,  vecs[k].ds,  vecs[k].dr,  1'b1) &&
           op_ok(uinstr_de0[0].src1, vecs[k].s1t, SZ_8B,       vecs[k].s1r, 1'b0) &&
           op_ok(uinstr_de0[0].src2, vecs[k].s2t, vecs[k].s2s, vecs[k].s2r, 1'b1) &&
           (uinstr_de0[0].imm64 === vecs[k].imm);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL dec_%s got dst=%h src1=%h src2=%h imm=%h exp dst=%s/%0d/%s src1=%s/%0d src2=%s/%0d/%s imm=%h",
                 vecs[k].name, uinstr_de0[0].dst, uinstr_de0[0].src1, uinstr_de0[0].src2,
                 uinstr_de0[0].imm64, vecs[k].dt.name(), vecs[k].dr, vecs[k].ds.name(),
                 vecs[k].s1t.name(), vecs[k].s1r, vecs[k].s2t.name(), vecs[k].s2r,
                 vecs[k].s2s.name(), vecs[k].imm);
      end
    end
    instr_fe1 = '0;
    @(posedge clk);
    #1;

    // Fill with rename stalled, then drain in program order
    for (int g = 0; g < 4; g++) begin
      drive_group(64'h100 + 64'(16 * g), 2'b11, I_ADDI, I_ADDI, 2);
      tick();
      check("fill_cnt",   64'(cnt), 64'(2 * (g + 1)));
      check("fill_ready", 64'(ready), 64'(g < 3));
    end
    drive_group(64'h200, 2'b11, I_ADDI, I_ADDI, 0);
    tick();
    check("full_ignored_cnt", 64'(cnt), 64'd8);
    valid_fe1    = '0;
    rename_ready = 1'b1;
    repeat (4) tick();
    check("drain_cnt", 64'(cnt), 64'd0);
    check("drain_sb",  64'(sb.size()), 64'd0);

    // Full throughput; first cycle must not bypass
    drive_group(64'h300, 2'b11, I_ADDI, I_ADDI, 2);
    #1;
    check("no_bypass", 64'(valid_de1), 64'd0);
    tick();
    check("thru_cnt0", 64'(cnt), 64'd2);
    for (int g = 1; g < 4; g++) begin
      drive_group(64'h300 + 64'(16 * g), 2'b11, I_ADDI, I_ADDI, 2);
      tick();
      check("thru_cnt", 64'(cnt), 64'd2);
    end
    valid_fe1 = '0;
    tick();
    check("thru_drain", 64'(cnt), 64'd0);
    rename_ready = 1'b0;

    // EBREAK group
    drive_group(64'h400, 2'b11, I_EBREAK, I_ADD, 1);
    tick();
    check("ebreak_cnt", 64'(cnt), 64'd1);
    drive_group(64'h410, 2'b11, I_ADDI, I_ADDI, 0);
    tick();
    check("ebreak_drop", 64'(cnt), 64'd1);
    valid_fe1    = '0;
    rename_ready = 1'b1;
    tick();
    check("ebreak_pop", 64'(cnt), 64'd0);
    rename_ready = 1'b0;
    drive_group(64'h420, 2'b11, I_ADDI, I_ADDI, 0);
    tick();
    check("ebreak_sticky", 64'(cnt), 64'd0);
    valid_fe1  = '0;
    nuke.valid = 1'b1;
    tick();
    nuke.valid = 1'b0;
    drive_group(64'h430, 2'b11, I_ADDI, I_ADDI, 2);
    tick();
    check("post_nuke_accept", 64'(cnt), 64'd2);
    valid_fe1    = '0;
    rename_ready = 1'b1;
    tick();
    check("post_nuke_drain", 64'(cnt), 64'd0);
    rename_ready = 1'b0;

    // Nuke with count=5 and rename ready
    drive_group(64'h500, 2'b11, I_ADDI, I_ADDI, 2);
    tick();
    drive_group(64'h510, 2'b11, I_ADDI, I_ADDI, 2);
    tick();
    drive_group(64'h520, 2'b01, I_ADDI, I_ADDI, 1);
    tick();
    check("nuke_pre_cnt", 64'(cnt), 64'd5);
    valid_fe1    = '0;
    rename_ready = 1'b1;
    nuke.valid   = 1'b1;
    #1;
    check("nuke_valid", 64'(valid_de1), 64'd0);
    tick();
    nuke.valid   = 1'b0;
    rename_ready = 1'b0;
    sb.delete();
    check("nuke_cnt",   64'(cnt), 64'd0);
    check("nuke_ready", 64'(ready), 64'd1);

    // Reset mid-operation with count=4
    drive_group(64'h600, 2'b11, I_ADDI, I_ADDI, 2);
    tick();
    drive_group(64'h610, 2'b11, I_ADDI, I_ADDI, 2);
    tick();
    check("rst_pre_cnt", 64'(cnt), 64'd4);
    #2;
    rename_ready = 1'b1;
    reset_n      = 1'b0;
    #1;
    check("arst_cnt",   64'(cnt), 64'd0);
    check("arst_ready", 64'(ready), 64'd0);
    check("arst_valid", 64'(valid_de1), 64'd0);
    check("arst_de0",   64'(|uinstr_de0), 64'd0);
    sb.delete();
    valid_fe1    = '0;
    rename_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_cnt",   64'(cnt), 64'd0);
    check("rel_ready", 64'(ready), 64'd1);
    drive_group(64'h700, 2'b11, I_ADDI, I_ADDI, 2);
    tick();
    check("rel_push_cnt", 64'(cnt), 64'd2);
    valid_fe1    = '0;
    rename_ready = 1'b1;
    tick();
    check("rel_drain_cnt", 64'(cnt), 64'd0);
    check("final_sb",      64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
